dc_strobe_gen: RTL and testbench
================================

# dc_strobe_gen

Burst generator that drives the `dc` strobe input of the datapath pulse counter and consumes its `count` terminal pulse as an acknowledge. On `start` it issues a programmed number of single-cycle `dc` pulses with a programmable idle gap between them. It then waits a bounded time for `count` and reports completion, with an error flag for timeout or premature acknowledge. The block sits in the datapath unit between the control sequencer and the counter.

## Interface
- `LW`, 3: width of burst-length field `len` and of `sent`.
- `GW`, 4: width of inter-pulse gap field `gap`.
- `TIMEOUT`, 8: maximum cycles spent in WAIT before declaring error (1..255).
- `clk`  in  1: single clock; all registers update on the falling edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a burst; sampled only in IDLE.
- `len`  in  LW: number of `dc` pulses to issue; latched on accepted `start`.
- `gap`  in  GW: idle cycles between consecutive pulses; latched on accepted `start`.
- `count`  in  1: terminal pulse from the counter (acknowledge).
- `dc`  out  1: strobe to the counter, registered, one cycle per pulse.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: burst ended by timeout or early `count`; valid with `done`, held until next accepted `start`.
- `sent`  out  LW: pulses issued in current/last burst; held until next accepted `start`.

## Operation
- States: IDLE, PULSE, GAP, WAIT, DONE. All outputs are Moore and registered: `dc`=1 only in PULSE, `done`=1 only in DONE, `busy`=1 outside IDLE.
- IDLE:
  - `start`=1 with `len`≠0: latch `len`/`gap`, clear `sent` and `err`, go to PULSE.
  - `start`=1 with `len`=0: clear `sent`/`err`, go to DONE, with no pulse.
  - Otherwise stay in IDLE.
- PULSE: `sent` increments on exit.
  - If the new `sent` equals the latched `len`, go to WAIT.
  - Else if latched `gap`=0, stay in PULSE (back-to-back pulses).
  - Else load the gap counter with `gap` and go to GAP.
- GAP: decrement the gap counter each cycle. On the cycle it reads 1, go to PULSE. `gap` cycles with `dc`=0 are inserted.
- WAIT: clear the timeout counter on entry and increment it each cycle.
  - `count`=1 goes to DONE with `err`=0.
  - Otherwise, if the counter reaches `TIMEOUT`, go to DONE with `err`=1.
- DONE: one cycle, then IDLE.
- Early acknowledge: `count`=1 sampled in PULSE or GAP aborts to DONE with `err`=1. The pulse in progress still completes its single cycle and is counted in `sent`.
- `start` outside IDLE is ignored, including in DONE.
- `count` in IDLE or DONE is ignored.
- `sent` saturates at `len` and never wraps. Latched `len`/`gap` are immune to input changes mid-burst.

## Timing
- Reset: asynchronous. All outputs are 0 immediately: `dc`, `busy`, `done`, `err`, `sent`. State goes to IDLE and the internal counters clear.
  - Reset mid-burst drops `dc` at once and issues no `done`.
- Edge numbering: `start` is sampled at falling edge 0. `dc` goes high after edge 0 and the first pulse occupies edges 0→1.
- Pulse k (1-based) rises at edge (k−1)·(gap+1).
- The counter samples `dc` on the same falling edge, so one PULSE cycle equals exactly one increment.
- Ideal acknowledge: the counter raises `count` in the cycle after the last pulse. DONE is entered at edge len+(len−1)·gap+1, `done` is high for one cycle, and IDLE follows on the next edge.
- Timeout: DONE is entered `TIMEOUT` edges after entering WAIT.
- A new `start` is accepted no earlier than the edge after DONE, so the minimum burst-to-burst spacing is one IDLE cycle.

## Test plan
- `len`=4, `gap`=0, `count` returned one cycle after the 4th pulse:
  - `dc` is high for edges 0–4.
  - `done` is high edge 5→6, with `err`=0 and `sent`=4.
  - `busy` is high edges 0–6.
- `len`=4, `gap`=2: `dc` is high at cycles starting at edges 0, 3, 6, 9, and `done` is asserted at edge 11.
- `len`=3, `count` never asserted, `TIMEOUT`=8: three pulses, WAIT is entered at edge 3, and `done` with `err`=1 occurs at edge 11, with `sent`=3.
- `len`=5, `gap`=1, `count` forced high during the GAP after pulse 2: DONE follows next edge with `err`=1, `sent`=2, and no further `dc`.
- `len`=0: `done` is asserted the edge after `start` with `dc` never high, `err`=0, and `sent`=0.
- Reset asserted during the 2nd pulse:
  - `dc` and `busy` drop asynchronously, and `done` never pulses.
  - After release, a new `start` with `len`=2 produces exactly two pulses.

Source files
------------

// File: rtl/dc_strobe_gen.sv
// ---------------------------------------------------------------------------
// dc_strobe_gen
//
// Burst generator for the datapath pulse counter. On an accepted start it
// issues len_i single-cycle dc strobes separated by gap_i idle cycles, then
// waits a bounded time for the counter's terminal pulse (count_i) as an
// acknowledge. Completion is reported with a one-cycle done pulse; err is set
// for a timeout or for an acknowledge that arrives before the burst finished.
// All registers update on the falling edge of clk_i.
//
// Ports
//   clk_i    in   1    clock, falling-edge active
//   rst_i    in   1    asynchronous reset, active high
//   start_i  in   1    burst request, sampled only in IDLE
//   len_i    in   LW   number of dc pulses, latched on accepted start
//   gap_i    in   GW   idle cycles between pulses, latched on accepted start
//   count_i  in   1    terminal pulse from the counter (acknowledge)
//   dc_o     out  1    strobe to the counter, one cycle per pulse
//   busy_o   out  1    high in every state except IDLE
//   done_o   out  1    one-cycle completion pulse
//   err_o    out  1    timeout / early acknowledge, held until next start
//   sent_o   out  LW   pulses issued in current/last burst
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start
// PULSE  | dc high for one cycle; sent counts the pulse on exit
// GAP    | dc low, gap down-counter running between two pulses
// WAIT   | all pulses issued, timeout down-counter waiting for count_i
// DONE   | one-cycle done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module dc_strobe_gen #(
    parameter int LW      = 3,
    parameter int GW      = 4,
    parameter int TIMEOUT = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [LW-1:0] len_i,
    input  logic [GW-1:0] gap_i,
    input  logic          count_i,
    output logic          dc_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [LW-1:0] sent_o
);

    // TIMEOUT is limited to 1..255, so an 8-bit timer always holds it.
    localparam int            TW       = 8;
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PULSE = 3'd1,
        S_GAP   = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] len_q,   len_d;
    logic [GW-1:0] gap_q,   gap_d;
    logic [GW-1:0] gcnt_q,  gcnt_d;
    logic [TW-1:0] tcnt_q,  tcnt_d;
    logic [LW-1:0] sent_q,  sent_d;
    logic          err_q,   err_d;
    logic          dc_q,    dc_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    logic [LW-1:0] sent_inc;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            tcnt_q  <= '0;
            sent_q  <= '0;
            err_q   <= 1'b0;
            dc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            tcnt_q  <= tcnt_d;
            sent_q  <= sent_d;
            err_q   <= err_d;
            dc_q    <= dc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Saturating pulse count: never wraps past the latched length.
    assign sent_inc = (sent_q == len_q) ? sent_q : sent_q + LW'(1);

    // -----------------------------------------------------------------------
    // Next-state and datapath update
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        tcnt_d  = tcnt_q;
        sent_d  = sent_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sent_d = '0;
                    err_d  = 1'b0;
                    if (len_i != '0) begin
                        len_d   = len_i;
                        gap_d   = gap_i;
                        state_d = S_PULSE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_PULSE: begin
                // The pulse in progress always completes and is counted,
                // even when an early acknowledge aborts the burst.
                sent_d = sent_inc;
                if (count_i) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (sent_inc == len_q) begin
                    tcnt_d  = TMO_LOAD;
                    state_d = S_WAIT;
                end else if (gap_q != '0) begin
                    gcnt_d  = gap_q;
                    state_d = S_GAP;
                end
            end

            S_GAP: begin
                gcnt_d = gcnt_q - GW'(1);
                if (count_i) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (gcnt_q == GW'(1)) begin
                    state_d = S_PULSE;
                end
            end

            S_WAIT: begin
                // Down-counter loaded with TIMEOUT on entry; reading 1 means
                // this is the TIMEOUT-th cycle spent waiting.
                tcnt_d = tcnt_q - TW'(1);
                if (count_i) begin
                    state_d = S_DONE;
                end else if (tcnt_q == TW'(1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Moore outputs, decoded from the next state so they leave flops
    // -----------------------------------------------------------------------
    always_comb begin
        dc_d   = (state_d == S_PULSE);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign dc_o   = dc_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;
    assign sent_o = sent_q;

endmodule

// File: tb/tb_dc_strobe_gen.sv
// ---------------------------------------------------------------------------
// tb_dc_strobe_gen
//
// Directed bench for dc_strobe_gen. The DUT works on the falling edge of the
// clock; stimulus is driven and outputs are sampled on the rising edge, so
// the cycle numbered k is the one between falling edges k and k+1, with the
// start accepted at falling edge 0. The bench stands in for the pulse
// counter: it raises count one cycle after it has seen the chosen pulse.
// ---------------------------------------------------------------------------
module tb_dc_strobe_gen;

    logic       clk_i;
    logic       rst_i;
    logic       start_i;
    logic [2:0] len_i;
    logic [3:0] gap_i;
    logic       count_i;
    logic       dc_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic [2:0] sent_o;

    int n_chk  = 0;
    int n_pass = 0;

    dc_strobe_gen #(
        .LW      (3),
        .GW      (4),
        .TIMEOUT (8)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .len_i   (len_i),
        .gap_i   (gap_i),
        .count_i (count_i),
        .dc_o    (dc_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .sent_o  (sent_o)
    );

    initial clk_i = 1'b1;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    endtask

    // One burst, entered and left on a rising edge. ack_at: pulse number
    // after which count is returned (0 = never). force_cyc: cycle in which
    // count is forced high. restart_cyc: cycle in which start is re-raised.
    // len/gap inputs are scrambled after acceptance to prove they are latched.
    task automatic burst_test(input string tag, input logic [2:0] l,
                              input logic [3:0] g, input int ack_at,
                              input int force_cyc, input int restart_cyc,
                              input int ncyc, input logic [63:0] exp_dc,
                              input logic [63:0] exp_busy, input int exp_dcyc,
                              input logic exp_err, input logic [2:0] exp_sent);
        logic [63:0] dc_tr   = '0;
        logic [63:0] busy_tr = '0;
        int          d_cyc   = -1;
        int          d_cnt   = 0;
        logic        d_err   = 1'bx;
        logic [2:0]  d_sent  = 'x;
        int          np      = 0;
        logic        ack_pend = 1'b0;

        start_i = 1'b1;
        len_i   = l;
        gap_i   = g;
        count_i = 1'b0;
        @(negedge clk_i);
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk_i);
            dc_tr[k]   = dc_o;
            busy_tr[k] = busy_o;
            if (done_o) begin
                if (d_cnt == 0) begin
                    d_cyc  = k;
                    d_err  = err_o;
                    d_sent = sent_o;
                end
                d_cnt++;
            end
            if (k == 0) begin
                len_i = 3'd7;
                gap_i = 4'd0;
            end
            start_i = (k == restart_cyc);
            count_i = ack_pend || (k == force_cyc);
            if (dc_o && ack_at != 0) begin
                np++;
                ack_pend = (np == ack_at);
            end else begin
                ack_pend = 1'b0;
            end
        end
        start_i = 1'b0;
        count_i = 1'b0;
        check_eq({tag, ".dc"},    dc_tr,          exp_dc);
        check_eq({tag, ".busy"},  busy_tr,        exp_busy);
        check_eq({tag, ".dcyc"},  64'(d_cyc),     64'(exp_dcyc));
        check_eq({tag, ".ndone"}, 64'(d_cnt),     64'd1);
        check_eq({tag, ".err"},   64'(d_err),     64'(exp_err));
        check_eq({tag, ".sent"},  64'(d_sent),    64'(exp_sent));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic done_seen;

        rst_i   = 1'b1;
        start_i = 1'b0;
        len_i   = '0;
        gap_i   = '0;
        count_i = 1'b0;
        #2;
        check_eq("rst.dc",   64'(dc_o),   64'd0);
        check_eq("rst.busy", 64'(busy_o), 64'd0);
        check_eq("rst.done", 64'(done_o), 64'd0);
        check_eq("rst.err",  64'(err_o),  64'd0);
        check_eq("rst.sent", 64'(sent_o), 64'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);

        // len=4 gap=0, ideal ack; start re-raised in DONE must be ignored
        burst_test("b2b", 3'd4, 4'd0, 4, -1, 5, 10,
                   64'hF, 64'h3F, 5, 1'b0, 3'd4);
        // len=4 gap=2: pulses in cycles 0,3,6,9, done at 11
        burst_test("gap2", 3'd4, 4'd2, 4, -1, -1, 16,
                   64'h249, 64'hFFF, 11, 1'b0, 3'd4);
        // len=3, no ack: WAIT from edge 3, timeout done at 11
        burst_test("tmo", 3'd3, 4'd0, 0, -1, -1, 16,
                   64'h7, 64'hFFF, 11, 1'b1, 3'd3);
        check_eq("tmo.err_hold", 64'(err_o), 64'd1);
        // len=5 gap=1, count forced in the GAP after pulse 2
        burst_test("early", 3'd5, 4'd1, 0, 3, -1, 12,
                   64'h5, 64'h1F, 4, 1'b1, 3'd2);
        check_eq("early.sent_hold", 64'(sent_o), 64'd2);
        // len=0: immediate done, no pulse, err cleared
        burst_test("len0", 3'd0, 4'd3, 0, -1, -1, 4,
                   64'h0, 64'h1, 0, 1'b0, 3'd0);

        // reset during the 2nd pulse of a back-to-back burst
        start_i = 1'b1;
        len_i   = 3'd4;
        gap_i   = 4'd0;
        @(negedge clk_i);
        @(posedge clk_i);
        start_i = 1'b0;
        @(posedge clk_i);
        check_eq("rstmid.dc_before", 64'(dc_o), 64'd1);
        #1 rst_i = 1'b1;
        #1;
        check_eq("rstmid.dc",   64'(dc_o),   64'd0);
        check_eq("rstmid.busy", 64'(busy_o), 64'd0);
        check_eq("rstmid.sent", 64'(sent_o), 64'd0);
        done_seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i);
            done_seen = done_seen | done_o;
        end
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i);
            done_seen = done_seen | done_o;
            count_i   = (k == 0);
        end
        count_i = 1'b0;
        check_eq("rstmid.no_done",   64'(done_seen), 64'd0);
        check_eq("rstmid.idle_busy", 64'(busy_o),    64'd0);
        burst_test("after_rst", 3'd2, 4'd1, 2, -1, -1, 8,
                   64'h5, 64'h1F, 4, 1'b0, 3'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
